// File: rtl/multi_digit_bcd_counter.sv
// Multi-digit synchronous BCD counter with up/down counting, clear, load with
// digit clamping, optional saturation, a combinational terminal count for
// cascading, and registered carry/borrow and load-error pulses.
module multi_digit_bcd_counter #(
  parameter int DIGITS = 2,
  parameter bit SAT    = 1'b0
) (
  input  logic                  Clk,
  input  logic                  Rst_b,
  input  logic                  En,
  input  logic                  Up,
  input  logic                  Clr,
  input  logic                  Load,
  input  logic [4*DIGITS-1:0]   D,
  output logic [4*DIGITS-1:0]   Q,
  output logic                  Tc,
  output logic                  Co,
  output logic                  Err
);

  localparam int W = 4 * DIGITS;

  logic [W-1:0]      q_q, q_d;
  logic              co_q, co_d;
  logic              err_q, err_d;

  // all9[k] / all0[k]: every digit below k is 9 / 0 (the ripple-enable chains)
  logic [DIGITS:0]   all9;
  logic [DIGITS:0]   all0;
  logic [DIGITS-1:0] bad_digit;
  logic [W-1:0]      load_val;
  logic [W-1:0]      cnt_val;
  logic              at_limit;

  assign all9[0] = 1'b1;
  assign all0[0] = 1'b1;

  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
    logic [3:0] cur;
    logic [3:0] din;
    logic [3:0] inc;
    logic [3:0] dec;

    assign cur = q_q[4*gi +: 4];
    assign din = D[4*gi +: 4];

    assign all9[gi+1] = all9[gi] & (cur == 4'd9);
    assign all0[gi+1] = all0[gi] & (cur == 4'd0);

    // Out-of-range load digits are clamped to 9 and flagged
    assign bad_digit[gi]       = (din > 4'd9);
    assign load_val[4*gi +: 4] = bad_digit[gi] ? 4'd9 : din;

    // A digit steps only when every lower digit sits at the rollover value
    assign inc = (cur >= 4'd9) ? 4'd0 : cur + 4'd1;
    assign dec = (cur == 4'd0) ? 4'd9 : cur - 4'd1;
    assign cnt_val[4*gi +: 4] = Up ? (all9[gi] ? inc : cur)
                                   : (all0[gi] ? dec : cur);
  end

  // The whole count sits at the limit for the current direction
  assign at_limit = Up ? all9[DIGITS] : all0[DIGITS];

  // Terminal count is combinational so a chained upper stage sees it in-cycle
  assign Tc = En & at_limit;

  // Next-state selection: clear beats load beats count beats hold
  always_comb begin
    q_d   = q_q;
    co_d  = 1'b0;
    err_d = 1'b0;
    if (Clr) begin
      q_d = '0;
    end else if (Load) begin
      q_d   = load_val;
      err_d = |bad_digit;
    end else if (En) begin
      if (SAT && at_limit) begin
        q_d = q_q;
      end else begin
        // cnt_val already rolls every digit over when at the limit
        q_d  = cnt_val;
        co_d = at_limit;
      end
    end
  end

  // State and pulse registers, cleared asynchronously
  always_ff @(posedge Clk or negedge Rst_b) begin
    if (!Rst_b) begin
      q_q   <= '0;
      co_q  <= 1'b0;
      err_q <= 1'b0;
    end else begin
      q_q   <= q_d;
      co_q  <= co_d;
      err_q <= err_d;
    end
  end

  assign Q   = q_q;
  assign Co  = co_q;
  assign Err = err_q;

endmodule

// File: tb/tb_multi_digit_bcd_counter.sv
// Bench: a wrapping and a saturating two-digit counter plus a cascaded pair of
// one-digit counters, all driven from shared stimulus and checked against an
// integer-valued reference model through a scoreboard.
module tb_multi_digit_bcd_counter;

  logic       Clk = 1'b0;
  logic       Rst_b, En, Up, Clr, Load;
  logic [7:0] D;

  logic [7:0] q0, q1;
  logic       tc0, tc1, co0, co1, err0, err1;
  logic [3:0] ql, qh;
  logic       tcl, tch, col, coh, errl, errh;

  multi_digit_bcd_counter #(.DIGITS(2), .SAT(1'b0)) u_wrap (
    .Clk(Clk), .Rst_b(Rst_b), .En(En), .Up(Up), .Clr(Clr), .Load(Load),
    .D(D), .Q(q0), .Tc(tc0), .Co(co0), .Err(err0));

  multi_digit_bcd_counter #(.DIGITS(2), .SAT(1'b1)) u_sat (
    .Clk(Clk), .Rst_b(Rst_b), .En(En), .Up(Up), .Clr(Clr), .Load(Load),
    .D(D), .Q(q1), .Tc(tc1), .Co(co1), .Err(err1));

  multi_digit_bcd_counter #(.DIGITS(1), .SAT(1'b0)) u_lo (
    .Clk(Clk), .Rst_b(Rst_b), .En(En), .Up(Up), .Clr(Clr), .Load(Load),
    .D(D[3:0]), .Q(ql), .Tc(tcl), .Co(col), .Err(errl));

  multi_digit_bcd_counter #(.DIGITS(1), .SAT(1'b0)) u_hi (
    .Clk(Clk), .Rst_b(Rst_b), .En(tcl), .Up(Up), .Clr(Clr), .Load(Load),
    .D(D[7:4]), .Q(qh), .Tc(tch), .Co(coh), .Err(errh));

  always #5 Clk = ~Clk;

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  int checks = 0;
  int fails  = 0;

  typedef struct {
    int         due;
    logic [7:0] q0, q1;
    logic       co0, co1, err0, err1;
  } st_exp_t;

  typedef struct {
    int   due;
    logic tc0, tc1;
  } tc_exp_t;

  st_exp_t stq[$];
  tc_exp_t tcq[$];

  // Reference model state: plain decimal values 0..99
  int m0, m1;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] bcd(input int v);
    logic [3:0] hi, lo;
    hi = 4'(v / 10);
    lo = 4'(v % 10);
    return {hi, lo};
  endfunction

  function automatic void mnext(input int v, input bit sat, input logic en, input logic up,
                                input logic clr, input logic load, input logic [7:0] d,
                                output int nv, output logic co, output logic err);
    int hi, lo;
    nv  = v;
    co  = 1'b0;
    err = 1'b0;
    hi  = int'(d[7:4]);
    lo  = int'(d[3:0]);
    if (clr) begin
      nv = 0;
    end else if (load) begin
      err = (hi > 9) || (lo > 9);
      if (hi > 9) hi = 9;
      if (lo > 9) lo = 9;
      nv = hi * 10 + lo;
    end else if (en) begin
      if (up) begin
        if (v == 99) begin
          if (!sat) begin nv = 0; co = 1'b1; end
        end else nv = v + 1;
      end else begin
        if (v == 0) begin
          if (!sat) begin nv = 99; co = 1'b1; end
        end else nv = v - 1;
      end
    end
  endfunction

  // Drive one edge's command and record what the DUTs must show
  task automatic step(input logic en, input logic up, input logic clr,
                      input logic load, input logic [7:0] d);
    tc_exp_t te;
    st_exp_t se;
    int      n0, n1;
    @(posedge Clk);
    #1;
    En = en; Up = up; Clr = clr; Load = load; D = d;
    te.due = cyc;
    te.tc0 = en && (up ? (m0 == 99) : (m0 == 0));
    te.tc1 = en && (up ? (m1 == 99) : (m1 == 0));
    tcq.push_back(te);
    mnext(m0, 1'b0, en, up, clr, load, d, n0, se.co0, se.err0);
    mnext(m1, 1'b1, en, up, clr, load, d, n1, se.co1, se.err1);
    m0 = n0;
    m1 = n1;
    se.due = cyc + 1;
    se.q0  = bcd(m0);
    se.q1  = bcd(m1);
    stq.push_back(se);
  endtask

  // Monitor: compares every due expectation away from the active edge
  always @(negedge Clk) begin
    tc_exp_t te;
    st_exp_t se;
    while (tcq.size() > 0 && tcq[0].due <= cyc) begin
      te = tcq.pop_front();
      chk("tc_wrap", {7'd0, tc0}, {7'd0, te.tc0});
      chk("tc_sat",  {7'd0, tc1}, {7'd0, te.tc1});
      chk("tc_casc", {7'd0, tch}, {7'd0, te.tc0});
    end
    while (stq.size() > 0 && stq[0].due <= cyc) begin
      se = stq.pop_front();
      $display("txn cyc=%0d q_wrap=%h q_sat=%h q_casc=%h%h co=%b%b err=%b%b",
               cyc, q0, q1, qh, ql, co0, co1, err0, err1);
      chk("q_wrap",   q0, se.q0);
      chk("q_sat",    q1, se.q1);
      chk("q_casc",   {qh, ql}, se.q0);
      chk("co_wrap",  {7'd0, co0}, {7'd0, se.co0});
      chk("co_sat",   {7'd0, co1}, {7'd0, se.co1});
      chk("co_casc",  {7'd0, coh}, {7'd0, se.co0});
      chk("err_wrap", {7'd0, err0}, {7'd0, se.err0});
      chk("err_sat",  {7'd0, err1}, {7'd0, se.err1});
      chk("err_casc", {7'd0, errl | errh}, {7'd0, se.err0});
    end
  end

  // Global time limit so the run can never hang
  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "time limit reached");
  end

  task automatic chk_reset_state(input string tag);
    chk({tag, "_q_wrap"}, q0, 8'h00);
    chk({tag, "_q_sat"},  q1, 8'h00);
    chk({tag, "_q_casc"}, {qh, ql}, 8'h00);
    chk({tag, "_co"},  {6'd0, co0, co1}, 8'h00);
    chk({tag, "_err"}, {6'd0, err0, err1}, 8'h00);
  endtask

  initial begin
    Rst_b = 1'b0; En = 1'b0; Up = 1'b1; Clr = 1'b0; Load = 1'b0; D = 8'h00;
    m0 = 0; m1 = 0;
    #2;
    chk_reset_state("reset");
    // Tc is combinational even while reset is held: En=1, down, Q=0
    #1; En = 1'b1; Up = 1'b0;
    #1;
    chk("reset_tc_down", {7'd0, tc0}, 8'h01);
    En = 1'b0; Up = 1'b1;
    #8;
    Rst_b = 1'b1;

    // Up count through a full wrap
    for (int i = 0; i < 100; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 8'h00);

    // Down count and borrow
    step(1'b0, 1'b0, 1'b0, 1'b1, 8'h10);
    for (int i = 0; i < 12; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);

    // Saturation at both limits
    step(1'b0, 1'b1, 1'b0, 1'b1, 8'h98);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b0, 1'b0, 1'b1, 8'h01);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);

    // Priority and clamp
    step(1'b1, 1'b1, 1'b0, 1'b1, 8'h3C);
    step(1'b1, 1'b1, 1'b1, 1'b1, 8'h3C);

    // Randomised commands
    for (int i = 0; i < 300; i++) begin
      int   r;
      logic en, up, clr, load;
      logic [7:0] d;
      r    = int'($urandom_range(0, 99));
      clr  = (r < 4);
      load = (r >= 4 && r < 18);
      en   = ($urandom_range(0, 9) < 8);
      up   = ($urandom_range(0, 2) != 0);
      d    = 8'($urandom);
      step(en, up, clr, load, d);
    end

    // Asynchronous reset in the middle of a count at 57
    step(1'b0, 1'b1, 1'b0, 1'b1, 8'h55);
    step(1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
    step(1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
    @(posedge Clk);
    @(negedge Clk);
    #1;
    Rst_b = 1'b0;
    #1;
    chk_reset_state("async_now");
    En = 1'b0;
    @(posedge Clk);
    #1;
    chk_reset_state("async_held");
    Rst_b = 1'b1;
    m0 = 0; m1 = 0;

    // Resume counting from reset
    for (int i = 0; i < 20; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 8'h00);

    // Drain the scoreboard
    @(posedge Clk);
    #1;
    En = 1'b0; Load = 1'b0; Clr = 1'b0;
    @(negedge Clk);
    @(negedge Clk);
    #1;
    checks++;
    if (stq.size() != 0 || tcq.size() != 0) begin
      fails++;
      $display("FAIL drain: got %0d pending, expected 0", stq.size() + tcq.size());
    end

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule

// File: doc/multi_digit_bcd_counter.md
# multi_digit_bcd_counter

Parametrised synchronous BCD counter: the next generation of the team's single-digit ripple-free BCD counter, generalised to `DIGITS` cascaded decades with up/down counting, count enable, synchronous clear/load, an optional saturate mode and carry/borrow outputs. It drives the lab display and timer paths directly. Its outputs also let several instances be chained into longer counters.

## Interface
Parameters:
- `DIGITS`, 2: number of BCD decades (1..8); counter width is 4*DIGITS bits.
- `SAT`, 0: 0 = wrap at the limits; 1 = saturate at 9…9 (up) or 0…0 (down).

Ports:
- `Clk`  input  1  clock; all state changes on the rising edge.
- `Rst_b`  input  1  asynchronous reset, active low.
- `En`  input  1  count enable.
- `Up`  input  1  direction: 1 = increment, 0 = decrement.
- `Clr`  input  1  synchronous clear to 0.
- `Load`  input  1  synchronous parallel load from `D`.
- `D`  input  4*DIGITS  load value; digit k occupies `D[4k+3:4k]`, and digit 0 is the least significant.
- `Q`  output  4*DIGITS  current count, packed in the same way as `D`.
- `Tc`  output  1  combinational terminal count, used for cascading.
- `Co`  output  1  registered one-cycle carry/borrow pulse on wrap.
- `Err`  output  1  registered one-cycle pulse when a load contained an invalid digit.

## Operation
- Reset (`Rst_b`=0, asynchronous): `Q`=0, `Co`=0, `Err`=0, held until `Rst_b` rises. `Tc` follows from `Q` and the inputs.
- Per-edge priority is `Clr` > `Load` > `En` count > hold.
- `Clr`=1:
  - `Q`←0, `Co`←0, `Err`←0.
  - Direction and `En` are ignored.
- `Load`=1 (and `Clr`=0):
  - Each digit of `D` greater than 9 is loaded as 9. Valid digits load unchanged.
  - `Err`←1 if any digit was greater than 9, else 0.
  - `Co`←0.
- Count (`En`=1, no `Clr` or `Load`), up (`Up`=1):
  - Digit 0 increments. Digit k increments only when all lower digits are 9; those lower digits go to 0.
  - A digit at 9 goes to 0.
  - Every digit is always 0..9. No binary value from A to F may ever appear.
- Count down (`Up`=0) mirrors this:
  - Digit k decrements only when all lower digits are 0; those lower digits go to 9.
  - A digit at 0 goes to 9.
- Limits:
  - The limit value is 9…9 when counting up and 0…0 when counting down.
  - `SAT`=0: a count step from the limit wraps, 9…9→0…0 up or 0…0→9…9 down, and sets `Co`←1.
  - `SAT`=1: a count step from the limit holds `Q`, and `Co` stays 0.
- `Co` and `Err` return to 0 on any edge that does not set them. Each is a pulse exactly one cycle wide.
- `Tc` = `En` & (`Up` ? `Q`==9…9 : `Q`==0…0). It is purely combinational and asserted in both `SAT` modes.
- Cascading: connect a lower instance's `Tc` to the upper instance's `En`, and share `Clk`, `Up`, `Clr` and `Rst_b` between them.
- Changing `Up` mid-count takes effect on the next edge with no extra state.
- Hold (`En`=0, no `Clr` or `Load`): `Q` is unchanged and `Co` and `Err` go to 0.

## Timing
- Latency is one edge: `Q` shows the new value after the rising edge on which the command is sampled.
- `Co` is high in the same cycle that `Q` first shows the wrapped value.
- `Err` is high in the same cycle that `Q` first shows the clamped load value.
- `Tc` settles combinationally within the cycle and has no register delay. This keeps chained counters free of skew.
- Asserting `Rst_b` in the middle of a count clears everything immediately, without waiting for an edge.
- On the first edge after `Rst_b` rises, inputs are sampled normally.
- Inputs must meet setup and hold to `Clk`. The block contains no synchronisers.

## Test plan
- Reset and up-wrap (`DIGITS`=2, `SAT`=0): `Rst_b` low for 5 ns, then `En`=1 and `Up`=1 for 100 edges.
  - Required: `Q` counts 00,01,…,09,10,…,99,00.
  - `Co`=1 only in the cycle where `Q`=00 after 99.
  - `Tc`=1 only while `Q`=99.
  - No nibble ever exceeds 9.
- Down-count and borrow: load 10, then `Up`=0 with `En`=1 for 12 edges.
  - Required: `Q` goes 09,08,…,00,99,98.
  - `Co` pulses once, coinciding with `Q`=99.
- Saturation (`SAT`=1):
  - Load 98, count up 3 edges. Required: `Q` = 99,99,99, `Co`=0 throughout, `Tc`=1 while at 99.
  - Load 01, count down 3 edges. Required: `Q` = 00,00,00.
- Priority and clamp:
  - `D`=8'h3C with `Load`=1 and `En`=1. Required: `Q`=39 and a one-cycle `Err` pulse.
  - Next cycle, `Clr`=1, `Load`=1, `En`=1 together. Required: `Q`=00 and `Err`=0.
- Async reset mid-count: drop `Rst_b` between edges while `Q`=57.
  - Required: `Q`=00 immediately, before the next edge, and no `Co` or `Err` pulse.
- Cascade: two `DIGITS`=1 instances, with the lower `Tc` driving the upper `En`.
  - Required: for 25 edges the pair behaves identically to one `DIGITS`=2 instance, reaching 25.
